// File: rtl/sprite_pkg.sv
// Purpose: shared constants, state encoding and per-axis move helpers for sprite motion.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: default screen/sprite sizes, FSM encoding, button bit indices, clamp/move functions.
package sprite_pkg;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_SPRITE_W = 16;
  localparam int DEF_SPRITE_H = 16;

  typedef enum logic {
    S_MANUAL = 1'b0,
    S_AUTO   = 1'b1
  } motionState_t;

  // Bit positions inside the {up,down,left,right} button bus.
  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;

  // Result of one bounce step on a single axis.
  typedef struct packed {
    logic       flip;  // direction must be inverted
    logic [9:0] pos;   // clamped new coordinate
  } axisMove_t;

  // Saturate a signed intermediate into [0, maxVal]; never wraps.
  function automatic logic [9:0] clampAxis(input logic signed [10:0] val,
                                           input logic signed [10:0] maxVal);
    if (val < 11'sd0) begin
      return 10'd0;
    end else if (val > maxVal) begin
      return maxVal[9:0];
    end else begin
      return val[9:0];
    end
  endfunction

  // Button-driven step: opposing buttons cancel each other.
  function automatic logic [9:0] manualAxis(input logic [9:0]         pos,
                                            input logic               dec,
                                            input logic               inc,
                                            input logic signed [10:0] step,
                                            input logic signed [10:0] maxVal);
    logic signed [10:0] sum;
    sum = signed'({1'b0, pos});
    if (inc && !dec) begin
      sum = sum + step;
    end else if (dec && !inc) begin
      sum = sum - step;
    end
    return clampAxis(sum, maxVal);
  endfunction

  // Bounce step: dirNeg=0 moves towards maxVal, dirNeg=1 towards 0.
  // Touching either edge (inclusive) clamps and requests a direction flip.
  function automatic axisMove_t bounceAxis(input logic [9:0]         pos,
                                           input logic               dirNeg,
                                           input logic signed [10:0] step,
                                           input logic signed [10:0] maxVal);
    logic signed [10:0] sum;
    axisMove_t          res;
    sum      = signed'({1'b0, pos}) + (dirNeg ? -step : step);
    res.pos  = clampAxis(sum, maxVal);
    res.flip = (sum <= 11'sd0) || (sum >= maxVal);
    return res;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Purpose: detects the end of the visible frame from VGA counters and divides frames into updates.
// Latency: oUpdate is combinational in the cycle the frame-end condition first appears; oTick follows one cycle later.
// Backpressure: none; counters may hold a value for many cycles, the edge detector still yields one event per frame.
// Ports: Clock, Reset (sync, active-high), iColumnCount/iRowCount (VGA counters), oTick (1-cycle pulse), oUpdate (position-update strobe).
module frame_tick_gen
  import sprite_pkg::*;
#(
  parameter int SCREEN_H  = DEF_SCREEN_H,
  parameter int FRAME_DIV = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [9:0] iColumnCount,
  input  logic [9:0] iRowCount,
  output logic       oTick,
  output logic       oUpdate
);

  localparam logic [3:0] DIV_LAST = 4'(FRAME_DIV - 1);

  logic       frameEnd;
  logic       condPrev;
  logic       tickEvent;
  logic       tickQ;
  logic [3:0] divCnt;

  assign frameEnd  = (iRowCount == 10'(SCREEN_H)) && (iColumnCount == 10'd0);
  // condPrev resets to 1 so a condition already present at reset release is not an edge.
  assign tickEvent = frameEnd && !condPrev;
  assign oUpdate   = tickEvent && (divCnt == DIV_LAST);
  assign oTick     = tickQ;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      condPrev <= 1'b1;
      tickQ    <= 1'b0;
      divCnt   <= 4'd0;
    end else begin
      condPrev <= frameEnd;
      tickQ    <= tickEvent;
      if (tickEvent) begin
        divCnt <= (divCnt == DIV_LAST) ? 4'd0 : divCnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Purpose: moves a sprite once per (divided) frame during vertical blanking, manual via buttons or auto-bounce.
// Latency: position registers change on the same edge that raises oFrameTick; buttons see 2 cycles of sync delay.
// Backpressure: none; outputs are held steady between updates so the downstream renderer never tears.
// Ports: Clock, Reset, iColumnCount/iRowCount (VGA counters), iButtons {up,down,left,right}, iAutoMode,
//        oPosX/oPosY (sprite top-left), oEnable (visible after first frame), oFrameTick (frame-end pulse).
module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int SCREEN_W  = DEF_SCREEN_W,
  parameter int SCREEN_H  = DEF_SCREEN_H,
  parameter int SPRITE_W  = DEF_SPRITE_W,
  parameter int SPRITE_H  = DEF_SPRITE_H,
  parameter int STEP      = 2,
  parameter int FRAME_DIV = 1,
  parameter int INIT_X    = 312,
  parameter int INIT_Y    = 232
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [9:0] iColumnCount,
  input  logic [9:0] iRowCount,
  input  logic [3:0] iButtons,
  input  logic       iAutoMode,
  output logic [9:0] oPosX,
  output logic [9:0] oPosY,
  output logic       oEnable,
  output logic       oFrameTick
);

  localparam logic signed [10:0] MAX_X  = 11'(SCREEN_W - SPRITE_W);
  localparam logic signed [10:0] MAX_Y  = 11'(SCREEN_H - SPRITE_H);
  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic [9:0]         INIT_X_V = 10'(INIT_X);
  localparam logic [9:0]         INIT_Y_V = 10'(INIT_Y);

  logic tick;
  logic update;

  frame_tick_gen #(
    .SCREEN_H  (SCREEN_H),
    .FRAME_DIV (FRAME_DIV)
  ) uFrameTick (
    .Clock        (Clock),
    .Reset        (Reset),
    .iColumnCount (iColumnCount),
    .iRowCount    (iRowCount),
    .oTick        (tick),
    .oUpdate      (update)
  );

  // Two-flop synchroniser for the asynchronous push-buttons.
  logic [3:0] btnMeta;
  logic [3:0] btnSync;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      btnMeta <= 4'd0;
      btnSync <= 4'd0;
    end else begin
      btnMeta <= iButtons;
      btnSync <= btnMeta;
    end
  end

  motionState_t state;
  motionState_t stateNext;
  logic [9:0]   posX;
  logic [9:0]   posY;
  logic [9:0]   nextX;
  logic [9:0]   nextY;
  // Direction flags: 0 = increasing coordinate, 1 = decreasing.
  logic         dirX;
  logic         dirY;
  logic         nextDirX;
  logic         nextDirY;
  axisMove_t    moveX;
  axisMove_t    moveY;
  logic         enableQ;

  // Mode only switches at an update; the move on that update still uses the old mode.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_MANUAL;
    end else if (update) begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = iAutoMode ? S_AUTO : S_MANUAL;
    nextX     = posX;
    nextY     = posY;
    nextDirX  = dirX;
    nextDirY  = dirY;
    moveX     = bounceAxis(posX, dirX, STEP_S, MAX_X);
    moveY     = bounceAxis(posY, dirY, STEP_S, MAX_Y);
    case (state)
      S_MANUAL: begin
        nextX = manualAxis(posX, btnSync[BTN_LEFT], btnSync[BTN_RIGHT], STEP_S, MAX_X);
        nextY = manualAxis(posY, btnSync[BTN_UP], btnSync[BTN_DOWN], STEP_S, MAX_Y);
      end
      S_AUTO: begin
        nextX    = moveX.pos;
        nextY    = moveY.pos;
        nextDirX = dirX ^ moveX.flip;
        nextDirY = dirY ^ moveY.flip;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      posX    <= INIT_X_V;
      posY    <= INIT_Y_V;
      dirX    <= 1'b0;
      dirY    <= 1'b0;
      enableQ <= 1'b0;
    end else begin
      if (update) begin
        posX <= nextX;
        posY <= nextY;
        dirX <= nextDirX;
        dirY <= nextDirY;
      end
      enableQ <= enableQ | tick;
    end
  end

  // Enable rises together with the first tick pulse and latches thereafter.
  assign oEnable    = enableQ | tick;
  assign oFrameTick = tick;
  assign oPosX      = posX;
  assign oPosY      = posY;

endmodule
